// File: rtl/rf_pkg.sv
// rf_pkg: shared clear-FSM states, bank constants and width helper for the banked register file
package rf_pkg;
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_e;
  localparam int BANK_GEN = 0;
  localparam int BANK_LBL = 1;
  function automatic int bank_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rf_clear_fsm.sv
// rf_clear_fsm: walks one bank clearing an entry per cycle, then pulses clr_done
module rf_clear_fsm import rf_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int BANK_W = 1,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  input  logic [BANK_W-1:0] clr_bank,
  output logic              clear_active,
  output logic [BANK_W-1:0] clear_bank,
  output logic [ADDR_W-1:0] clear_ptr,
  output logic              busy,
  output logic              clr_done
);
  clr_state_e state, state_nx;
  logic [BANK_W-1:0] bank_nx;
  logic [ADDR_W-1:0] ptr_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      clear_bank <= '0;
      clear_ptr  <= '0;
    end else begin
      state      <= state_nx;
      clear_bank <= bank_nx;
      clear_ptr  <= ptr_nx;
    end
  always_comb begin
    state_nx = state;
    bank_nx  = clear_bank;
    ptr_nx   = clear_ptr;
    case (state)
      IDLE: if (clr_req) begin
        state_nx = CLEAR;
        bank_nx  = clr_bank;
        ptr_nx   = '0;
      end
      CLEAR: begin
        ptr_nx   = clear_ptr + 1'b1;
        state_nx = (clear_ptr == ADDR_W'(DEPTH - 1)) ? DONE : CLEAR;
      end
      default: state_nx = IDLE;
    endcase
  end
  assign clear_active = state == CLEAR;
  assign busy         = clear_active;
  assign clr_done     = state == DONE;
endmodule

// File: rtl/banked_register_file.sv
// banked_register_file: NUM_BANKS x DEPTH x WIDTH registers, two registered read ports with write bypass, bulk clear
module banked_register_file import rf_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int NUM_BANKS = 2,
  parameter int ZERO_REG = 1,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int BANK_W = bank_w(NUM_BANKS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [BANK_W-1:0] rd_bank,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic              we,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [ADDR_W-1:0] rd,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              clr_req,
  input  logic [BANK_W-1:0] clr_bank,
  output logic [WIDTH-1:0]  rdata_a,
  output logic [WIDTH-1:0]  rdata_b,
  output logic              rvalid,
  output logic              busy,
  output logic              clr_done,
  output logic              wr_drop
);
  logic [WIDTH-1:0] mem [NUM_BANKS][DEPTH];
  logic clear_active;
  logic [BANK_W-1:0] clear_bank;
  logic [ADDR_W-1:0] clear_ptr;
  logic wr_valid, clr_valid, wr_zero, wr_clr, wr_ok, drop, rd_blank, zero_a, zero_b;
  logic [WIDTH-1:0] val_a, val_b;
  rf_clear_fsm #(.DEPTH(DEPTH), .BANK_W(BANK_W)) u_clear (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .clr_bank(clr_bank),
    .clear_active(clear_active), .clear_bank(clear_bank), .clear_ptr(clear_ptr),
    .busy(busy), .clr_done(clr_done)
  );
  // Zero-register writes vanish silently; only bad banks and the bank being cleared raise wr_drop
  always_comb begin
    wr_valid  = int'(wr_bank) < NUM_BANKS;
    clr_valid = int'(clear_bank) < NUM_BANKS;
    wr_zero   = ZERO_REG != 0 && int'(wr_bank) == BANK_GEN && rd == '0;
    wr_clr    = clear_active && wr_bank == clear_bank;
    wr_ok     = we && wr_valid && !wr_clr && !wr_zero;
    drop      = we && (!wr_valid || (wr_clr && !wr_zero));
    rd_blank  = int'(rd_bank) >= NUM_BANKS || (clear_active && rd_bank == clear_bank);
    zero_a    = ZERO_REG != 0 && int'(rd_bank) == BANK_GEN && rs1 == '0;
    zero_b    = ZERO_REG != 0 && int'(rd_bank) == BANK_GEN && rs2 == '0;
    val_a     = (rd_blank || zero_a) ? '0 : (wr_ok && wr_bank == rd_bank && rd == rs1) ? wdata : mem[rd_bank][rs1];
    val_b     = (rd_blank || zero_b) ? '0 : (wr_ok && wr_bank == rd_bank && rd == rs2) ? wdata : mem[rd_bank][rs2];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rdata_a <= '0;
      rdata_b <= '0;
      rvalid  <= 1'b0;
      wr_drop <= 1'b0;
    end else begin
      rvalid  <= rd_en;
      wr_drop <= drop;
      if (rd_en) begin
        rdata_a <= val_a;
        rdata_b <= val_b;
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++)
        for (int i = 0; i < DEPTH; i++)
          mem[b][i] <= '0;
    end else begin
      if (clear_active && clr_valid) mem[clear_bank][clear_ptr] <= '0;
      if (wr_ok) mem[wr_bank][rd] <= wdata;
    end
endmodule

// File: tb/tb_banked_register_file.sv
// tb_banked_register_file: vector table, directed clear/reset sequences and random traffic against a reference model
module tb_banked_register_file;
  localparam int DEPTH = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  logic rd_en, rd_bank, we, wr_bank, clr_req, clr_bank;
  logic [2:0] rs1, rs2, rd;
  logic [7:0] wdata, rdata_a, rdata_b;
  logic rvalid, busy, clr_done, wr_drop;
  logic rd_en3, we3, clr_req3;
  logic [1:0] rd_bank3, wr_bank3, clr_bank3;
  logic [2:0] rs13, rs23, rd3;
  logic [7:0] wdata3, rdata_a3, rdata_b3;
  logic rvalid3, busy3, clr_done3, wr_drop3;
  int total = 0, bad = 0;
  logic [7:0] m_mem [2][DEPTH];
  int m_idx;
  logic m_cbank;
  logic [7:0] e_a, e_b;
  logic e_rv, e_busy, e_done, e_drop;

  banked_register_file u_dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_bank(rd_bank), .rs1(rs1), .rs2(rs2),
    .we(we), .wr_bank(wr_bank), .rd(rd), .wdata(wdata), .clr_req(clr_req), .clr_bank(clr_bank),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .rvalid(rvalid), .busy(busy), .clr_done(clr_done), .wr_drop(wr_drop)
  );
  banked_register_file #(.NUM_BANKS(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en3), .rd_bank(rd_bank3), .rs1(rs13), .rs2(rs23),
    .we(we3), .wr_bank(wr_bank3), .rd(rd3), .wdata(wdata3), .clr_req(clr_req3), .clr_bank(clr_bank3),
    .rdata_a(rdata_a3), .rdata_b(rdata_b3), .rvalid(rvalid3), .busy(busy3), .clr_done(clr_done3), .wr_drop(wr_drop3)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation still running at %0t, required finish", $time);
    $fatal(1, "timeout");
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h, required %0h", n, $time, act, exp);
    end
  endtask

  task automatic idle();
    rd_en = 0; rd_bank = 0; rs1 = 0; rs2 = 0; we = 0; wr_bank = 0; rd = 0; wdata = 0; clr_req = 0; clr_bank = 0;
  endtask

  task automatic model_reset();
    foreach (m_mem[b, i]) m_mem[b][i] = '0;
    m_idx = -1; m_cbank = 0;
    e_a = 0; e_b = 0; e_rv = 0; e_busy = 0; e_done = 0; e_drop = 0;
  endtask

  function automatic logic [7:0] mread(input logic [2:0] i, input bit clearing, input bit wok);
    if (clearing && rd_bank == m_cbank) return 8'h00;
    if (rd_bank == 1'b0 && i == 3'd0) return 8'h00;
    if (wok && wr_bank == rd_bank && rd == i) return wdata;
    return m_mem[rd_bank][i];
  endfunction

  // Predict what the registers show after the coming edge, then compare there
  task automatic step();
    bit clearing, wz, wclr, wok;
    clearing = m_idx >= 0 && m_idx < DEPTH;
    wz = we && wr_bank == 1'b0 && rd == 3'd0;
    wclr = clearing && wr_bank == m_cbank;
    wok = we && !wclr && !wz;
    if (rd_en) begin
      e_a = mread(rs1, clearing, wok);
      e_b = mread(rs2, clearing, wok);
    end
    e_rv = rd_en;
    e_drop = we && wclr && !wz;
    if (m_idx < 0) begin
      if (clr_req) begin m_idx = 0; m_cbank = clr_bank; end
    end else if (m_idx == DEPTH) m_idx = -1;
    else begin
      m_mem[m_cbank][m_idx] = 8'h00;
      m_idx++;
    end
    if (wok) m_mem[wr_bank][rd] = wdata;
    e_busy = m_idx >= 0 && m_idx < DEPTH;
    e_done = m_idx == DEPTH;
    @(posedge clk); #1;
    chk("rdata_a", rdata_a, e_a);
    chk("rdata_b", rdata_b, e_b);
    chk("rvalid", rvalid, e_rv);
    chk("busy", busy, e_busy);
    chk("clr_done", clr_done, e_done);
    chk("wr_drop", wr_drop, e_drop);
    idle();
  endtask

  task automatic rd_chk(input logic b, input logic [2:0] a1, input logic [2:0] a2, input logic [7:0] x1, input logic [7:0] x2, input string n);
    rd_en = 1; rd_bank = b; rs1 = a1; rs2 = a2;
    step();
    chk({n, "_a"}, rdata_a, x1);
    chk({n, "_b"}, rdata_b, x2);
  endtask

  task automatic step3(input string n, input logic [7:0] xa, input logic xv, input logic xd);
    @(posedge clk); #1;
    chk({n, "_rdata_a"}, rdata_a3, xa);
    chk({n, "_rvalid"}, rvalid3, xv);
    chk({n, "_wr_drop"}, wr_drop3, xd);
    rd_en3 = 0; we3 = 0; rd_bank3 = 0; wr_bank3 = 0; rs13 = 0; rd3 = 0; wdata3 = 0;
  endtask

  typedef struct {
    logic rd_en; logic rd_bank; logic [2:0] rs1, rs2;
    logic we; logic wr_bank; logic [2:0] rd; logic [7:0] wdata;
    logic [7:0] ea, eb; logic erv, edrop;
  } vec_t;

  initial begin
    vec_t vt [8];
    int nb, nd;
    vt[0] = '{0, 0, 0, 0, 1, 0, 3, 8'hA5, 8'h00, 8'h00, 0, 0};
    vt[1] = '{1, 0, 3, 3, 0, 0, 0, 8'h00, 8'hA5, 8'hA5, 1, 0};
    vt[2] = '{0, 0, 0, 0, 0, 0, 0, 8'h00, 8'hA5, 8'hA5, 0, 0};
    vt[3] = '{1, 1, 2, 2, 1, 1, 2, 8'h3C, 8'h3C, 8'h3C, 1, 0};
    vt[4] = '{1, 0, 0, 0, 1, 0, 0, 8'h77, 8'h00, 8'h00, 1, 0};
    vt[5] = '{1, 0, 0, 3, 0, 0, 0, 8'h00, 8'h00, 8'hA5, 1, 0};
    vt[6] = '{1, 1, 2, 3, 0, 0, 0, 8'h00, 8'h3C, 8'h00, 1, 0};
    vt[7] = '{1, 0, 7, 6, 1, 0, 7, 8'h5E, 8'h5E, 8'h00, 1, 0};
    idle();
    rd_en3 = 0; we3 = 0; clr_req3 = 0; rd_bank3 = 0; wr_bank3 = 0; clr_bank3 = 0;
    rs13 = 0; rs23 = 0; rd3 = 0; wdata3 = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rdata_a", rdata_a, 0);
    chk("reset_rdata_b", rdata_b, 0);
    chk("reset_rvalid", rvalid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_clr_done", clr_done, 0);
    chk("reset_wr_drop", wr_drop, 0);
    rst_n = 1;

    for (int k = 0; k < 8; k++) begin
      rd_en = vt[k].rd_en; rd_bank = vt[k].rd_bank; rs1 = vt[k].rs1; rs2 = vt[k].rs2;
      we = vt[k].we; wr_bank = vt[k].wr_bank; rd = vt[k].rd; wdata = vt[k].wdata;
      step();
      chk($sformatf("vec%0d_a", k), rdata_a, vt[k].ea);
      chk($sformatf("vec%0d_b", k), rdata_b, vt[k].eb);
      chk($sformatf("vec%0d_rvalid", k), rvalid, vt[k].erv);
      chk($sformatf("vec%0d_wr_drop", k), wr_drop, vt[k].edrop);
    end

    // Fill bank 1 and clear it
    for (int i = 0; i < DEPTH; i++) begin
      we = 1; wr_bank = 1; rd = 3'(i); wdata = 8'(8'h11 * (i + 1));
      step();
    end
    rd_chk(1, 4, 7, 8'h55, 8'h88, "fill");
    clr_req = 1; clr_bank = 1;
    nb = 0; nd = 0;
    step();
    for (int c = 0; c < 20 && nd == 0; c++) begin
      if (busy) nb++;
      if (clr_done) nd++;
      if (nd == 0) step();
    end
    chk("clear_busy_len", nb, DEPTH);
    chk("clear_done_seen", nd, 1);
    step();
    chk("clear_done_once", clr_done, 0);
    for (int i = 0; i < DEPTH; i += 2) rd_chk(1, 3'(i), 3'(i + 1), 0, 0, "cleared");
    rd_chk(0, 3, 7, 8'hA5, 8'h5E, "bank0_kept");

    // Traffic during a clear of bank 1
    clr_req = 1; clr_bank = 1;
    step();
    nb = busy ? 1 : 0; nd = 0;
    for (int c = 1; c < 20 && nd == 0; c++) begin
      if (c == 1) begin we = 1; wr_bank = 1; rd = 5; wdata = 8'hFF; end
      if (c == 2) begin we = 1; wr_bank = 0; rd = 5; wdata = 8'hFF; end
      if (c == 3) begin clr_req = 1; clr_bank = 1; end
      step();
      if (c == 1) chk("drop_clearing_bank", wr_drop, 1);
      if (c == 2) chk("other_bank_no_drop", wr_drop, 0);
      if (busy) nb++;
      if (clr_done) nd++;
    end
    chk("mid_clear_busy_len", nb, DEPTH);
    chk("mid_clear_done", nd, 1);
    step();
    chk("second_req_ignored", busy, 0);
    rd_chk(1, 5, 0, 0, 0, "dropped_write");
    rd_chk(0, 5, 3, 8'hFF, 8'hA5, "other_bank_write");

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      rd_en = 1'($urandom); rd_bank = 1'($urandom); rs1 = 3'($urandom); rs2 = 3'($urandom);
      we = 1'($urandom); wr_bank = 1'($urandom); rd = 3'($urandom); wdata = 8'($urandom);
      clr_req = $urandom_range(0, 15) == 0; clr_bank = 1'($urandom);
      step();
    end
    while (busy || clr_done) step();

    // Reset in the middle of a clear
    for (int i = 1; i < DEPTH; i++) begin
      we = 1; wr_bank = 0; rd = 3'(i); wdata = 8'(i + 8'h40);
      step();
    end
    clr_req = 1; clr_bank = 0;
    step();
    repeat (3) step();
    rd_en = 1; rd_bank = 1; rs1 = 1;
    rst_n = 0;
    #1;
    chk("async_rdata_a", rdata_a, 0);
    chk("async_rdata_b", rdata_b, 0);
    chk("async_rvalid", rvalid, 0);
    chk("async_busy", busy, 0);
    chk("async_clr_done", clr_done, 0);
    chk("async_wr_drop", wr_drop, 0);
    idle();
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
    nd = 0;
    for (int c = 0; c < DEPTH + 2; c++) begin
      step();
      if (clr_done) nd++;
    end
    chk("no_done_after_abort", nd, 0);
    for (int i = 0; i < DEPTH; i += 2) begin
      rd_chk(0, 3'(i), 3'(i + 1), 0, 0, "post_reset_b0");
      rd_chk(1, 3'(i), 3'(i + 1), 0, 0, "post_reset_b1");
    end

    // Three-bank instance: out-of-range bank handling
    we3 = 1; wr_bank3 = 3; rd3 = 1; wdata3 = 8'h99;
    step3("w_bank3", 0, 0, 1);
    step3("after_drop", 0, 0, 0);
    rd_en3 = 1; rd_bank3 = 3; rs13 = 1;
    step3("r_bank3", 0, 1, 0);
    rd_en3 = 1; rd_bank3 = 3; rs13 = 2; we3 = 1; wr_bank3 = 3; rd3 = 2; wdata3 = 8'h77;
    step3("byp_bank3", 0, 1, 1);
    rd_en3 = 1; rd_bank3 = 1; rs13 = 1;
    step3("r_bank1_alias", 0, 1, 0);
    we3 = 1; wr_bank3 = 2; rd3 = 4; wdata3 = 8'h5A;
    step3("w_bank2", 0, 0, 0);
    rd_en3 = 1; rd_bank3 = 2; rs13 = 4;
    step3("r_bank2", 8'h5A, 1, 0);
    chk("r_bank2_b", rdata_b3, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
